// File: rtl/sdrc_reqgen_checker.sv
// White-box checker for the SDRAM request generator: predicts bank/row/col
// requests from accepted application requests and checks them in order.
module sdrc_reqgen_checker #(
  parameter int ADDR_W    = 26,
  parameter int ROW_W     = 13,
  parameter int COL_W     = 13,
  parameter int NUM_BANKS = 4,
  parameter int LEN_W     = 7,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 16,
  localparam int BA_W     = $clog2(NUM_BANKS),
  localparam int PW       = $clog2(DEPTH) + 1
) (
  input  logic                       whbox_Clk,
  input  logic                       whbox_Reset,
  input  logic                       mon_en,
  input  logic [1:0]                 cfg_colbits,
  input  logic [1:0]                 sdr_width,
  input  logic                       app_req,
  input  logic                       app_req_ack,
  input  logic [ADDR_W-1:0]          app_req_addr,
  input  logic [LEN_W-1:0]           app_req_len,
  input  logic                       app_wrap,
  input  logic                       app_wren,
  input  logic                       r2b_req,
  input  logic                       b2r_arb_ok,
  input  logic [BA_W-1:0]            r2b_ba,
  input  logic [ROW_W-1:0]           r2b_raddr,
  input  logic [COL_W-1:0]           r2b_caddr,
  input  logic                       r2b_write,
  output logic                       err_map,
  output logic                       err_dir,
  output logic                       err_unexpected,
  output logic                       err_overflow,
  output logic [NUM_BANKS*CNT_W-1:0] bank_cnt,
  output logic [CNT_W-1:0]           split_cnt,
  output logic [PW-1:0]              pending,
  output logic                       fifo_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  // Wide enough for the shifted address, the split carry and the length sum.
  localparam int MW = ADDR_W + BA_W + ROW_W + LEN_W + 14;

  typedef struct packed {
    logic [BA_W-1:0]  ba;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             wren;
  } exp_t;

  function automatic exp_t map_entry(input logic [MW-1:0] m, input logic [3:0] cb, input logic w);
    logic [MW-1:0] hi;
    logic [MW-1:0] lo;
    hi = m >> cb;
    lo = m & ((MW'(1) << cb) - MW'(1));
    map_entry.ba   = hi[BA_W-1:0];
    map_entry.row  = hi[BA_W +: ROW_W];
    map_entry.col  = lo[COL_W-1:0];
    map_entry.wren = w;
  endfunction

  exp_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_nxt;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic [NUM_BANKS-1:0][CNT_W-1:0] bcnt_q;
  logic [CNT_W-1:0] split_q;
  logic err_map_q, err_dir_q, err_unexp_q, err_ovf_q;

  logic [1:0]    shift;
  logic [3:0]    cb;
  logic [MW-1:0] map, map2, col_mask;
  logic          split, app_acc, bk_acc, empty, do_pop, do_push;
  logic [PW:0]   need, free;
  exp_t          e0, e1, head;

  always_comb begin
    shift    = (sdr_width == 2'd3) ? 2'd0 : sdr_width;
    cb       = 4'd8 + {2'b00, cfg_colbits};
    map      = MW'(app_req_addr) << shift;
    col_mask = (MW'(1) << cb) - MW'(1);
    // Second half of a page-crossing request starts at column 0 of the next page.
    map2     = (map & ~col_mask) + (MW'(1) << cb);
    split    = !app_wrap && (((map & col_mask) + MW'(app_req_len)) > (MW'(1) << cb));
    e0       = map_entry(map, cb, app_wren);
    e1       = map_entry(map2, cb, app_wren);
  end

  assign app_acc = mon_en && app_req && app_req_ack;
  assign bk_acc  = mon_en && r2b_req && b2r_arb_ok;
  assign empty   = (cnt_q == '0);
  assign do_pop  = bk_acc && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign need    = split ? (PW+1)'(2) : (PW+1)'(1);
  // A same-cycle pop frees its slot for the push.
  assign free    = (PW+1)'(DEPTH) - {1'b0, cnt_q} + {{PW{1'b0}}, do_pop};
  assign do_push = app_acc && (need <= free);
  assign wr_nxt  = wr_ptr_q + PTR_W'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + (split ? PTR_W'(2) : PTR_W'(1));
      cnt_d    = cnt_d + (split ? PW'(2) : PW'(1));
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d    = cnt_d - PW'(1);
    end
  end

  always_ff @(posedge whbox_Clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= e0;
      if (split) mem_q[wr_nxt] <= e1;
    end
  end

  always_ff @(posedge whbox_Clk or posedge whbox_Reset) begin
    if (whbox_Reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      split_q     <= '0;
      err_map_q   <= 1'b0;
      err_dir_q   <= 1'b0;
      err_unexp_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      if (do_push && split && !(&split_q)) split_q <= split_q + CNT_W'(1);
      err_map_q   <= do_pop && ((head.ba != r2b_ba) || (head.row != r2b_raddr) ||
                                (head.col != r2b_caddr));
      err_dir_q   <= do_pop && (head.wren != r2b_write);
      err_unexp_q <= bk_acc && empty;
      err_ovf_q   <= app_acc && !do_push;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    always_ff @(posedge whbox_Clk or posedge whbox_Reset) begin
      if (whbox_Reset)
        bcnt_q[b] <= '0;
      else if (bk_acc && (r2b_ba == BA_W'(b)) && !(&bcnt_q[b]))
        bcnt_q[b] <= bcnt_q[b] + CNT_W'(1);
    end
  end

  assign err_map        = err_map_q;
  assign err_dir        = err_dir_q;
  assign err_unexpected = err_unexp_q;
  assign err_overflow   = err_ovf_q;
  assign bank_cnt       = bcnt_q;
  assign split_cnt      = split_q;
  assign pending        = cnt_q;
  assign fifo_empty     = empty;
endmodule
